chord_voice_allocator: RTL and testbench
========================================

// Module: chord_voice_allocator
// PURPOSE
//  Schedules incoming notes onto NUM_VOICES note_player voices of the chord/harmonic player.
//  Accepts one note per valid/ready handshake and picks a target voice: lowest-index free voice,
//  else the voice with the fewest remaining beats (steal). Drives a one-hot load strobe plus the
//  shared note/duration bus, and tracks per-voice busy state and remaining-beat counters.
//  Sits between the song reader and the voice array; replaces ad-hoc count==0 voice selection.
// PARAMETERS
//  NUM_VOICES  3  number of voices driven (2..8)
//  NOTE_W      6  note code width
//  DUR_W       6  duration width, in 1/48 s beats
//  STEAL_EN    1  1: steal when all voices busy; 0: stall request until a voice frees
// PORTS
//  clk             in   1           system clock; single clock domain
//  reset           in   1           asynchronous, active-low reset
//  play_enable     in   1           0 freezes beat counting and grants; handshake still accepted
//  beat            in   1           1-cycle 1/48 s tick
//  req_valid       in   1           new note offered (hold until req_ready)
//  req_note        in   NOTE_W      note code; 0 = rest
//  req_duration    in   DUR_W       note length in beats
//  req_ready       out  1           allocator can accept a note this cycle
//  voice_done      in   NUM_VOICES  per-voice note_done from note players
//  voice_load      out  NUM_VOICES  one-hot 1-cycle load strobe
//  voice_note      out  NOTE_W      note for the strobed voice; 0 when voice_load==0
//  voice_duration  out  DUR_W       duration for the strobed voice; 0 when voice_load==0
//  voice_busy      out  NUM_VOICES  voice currently holding a note
//  steal_pulse     out  1           1-cycle: current grant evicted a busy voice
//  all_idle        out  1           no busy voice and FSM in IDLE (chord finished)
// BEHAVIOUR
//  Reset (async): FSM=IDLE, buffer empty, all counters 0, voice_busy=0, voice_load=0,
//   voice_note/voice_duration=0, steal_pulse=0, req_ready=1, all_idle=1. Mid-operation reset
//   drops the pending note; no strobe is issued after reset release until a new request.
//  FSM: IDLE -> (req_valid&req_ready) latch note/duration -> GRANT.
//   GRANT: if play_enable=0, stay. If req_duration==0 or req_note==0 (rest): no strobe -> IDLE.
//   Else if free voice exists, or STEAL_EN=1: strobe voice_load for exactly 1 cycle -> IDLE.
//   Else (STEAL_EN=0, all busy) -> STALL; STALL -> GRANT the first cycle any voice frees.
//  req_ready=1 only in IDLE; latency accept -> voice_load = 1 cycle (minimum), 2 back-to-back
//   notes need >=2 cycles each.
//  Target select (combinational on GRANT entry): lowest index with busy=0; if none, voice with
//   smallest remaining count, ties -> lowest index; steal_pulse asserted with that strobe.
//  Per-voice counter: loaded with duration on strobe, busy<=1. On beat & play_enable & count>0:
//   count-1; reaching 0 clears busy. voice_done=1 also clears busy and zeroes count.
//  Simultaneous: strobe to voice v in same cycle as its expiry/voice_done -> load wins (busy=1,
//   count=new duration). beat during strobe cycle does not decrement the newly loaded count.
//  Widths: counters DUR_W, no wrap (saturate at 0); duration 63 legal. all_idle registered-free,
//   derived = (voice_busy==0)&&(state==IDLE).
// STRUCTURE
//  Shared package/header chord_pkg.vh: state encodings (ST_IDLE, ST_GRANT, ST_STALL),
//   MAX_VOICES, REST_NOTE=0. One sub-module: voice_slot (busy flag + beat counter,
//   load/decrement/clear priority), generated NUM_VOICES times; selection and FSM in top.
// TESTING
//  1 Reset low mid-GRANT -> next cycle voice_load=0, voice_busy=0, req_ready=1, all_idle=1.
//  2 Three notes (n=10/d=4, 20/8, 30/2) with idle voices -> voice_load 001,010,100 each 1 cycle
//    after accept; voice_busy=111; voice 2 frees after 2 beats, voice 0 after 4.
//  3 STEAL_EN=1, voices counts {5,2,2}, new note 40/6 -> voice_load=010, steal_pulse=1, count1=6.
//  4 STEAL_EN=0, all busy -> req_ready=0 in STALL; voice_done[2]=1 -> next cycle voice_load=100.
//  5 Rest (note 0, dur 3) -> accepted, no voice_load, no busy change, req_ready back after 2 cyc.
//  6 play_enable=0 with beats -> counts frozen, pending note held; re-enable -> strobe 1 cycle later.

Source files
------------

// File: rtl/chord_voice_allocator_pkg.sv
// Shared definitions for the chord voice allocator: FSM state encoding and note constants.
package chord_voice_allocator_pkg;

    localparam int MAX_VOICES = 8;
    localparam int REST_NOTE  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_STALL = 2'd2
    } state_e;

endpackage

// File: rtl/chord_voice_allocator_voice_slot.sv
// One voice slot: busy flag plus remaining-beat counter. A load beats a clear, and a clear beats a decrement.
module voice_slot
    import chord_voice_allocator_pkg::*;
#(
    parameter int DUR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play_enable_i,
    input  logic             beat_i,
    input  logic             load_i,
    input  logic             done_i,
    input  logic [DUR_W-1:0] load_dur_i,
    output logic             busy_o,
    output logic             busy_next_o,
    output logic [DUR_W-1:0] count_o
);

    localparam logic [DUR_W-1:0] ONE = DUR_W'(1);

    logic             busy_q;
    logic             busy_d;
    logic [DUR_W-1:0] count_q;
    logic [DUR_W-1:0] count_d;

    // Next-state for busy and count. The counter saturates at zero, and the last beat frees the voice.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        if (load_i) begin
            busy_d  = 1'b1;
            count_d = load_dur_i;
        end else if (done_i) begin
            busy_d  = 1'b0;
            count_d = '0;
        end else if (beat_i && play_enable_i && (count_q != '0)) begin
            count_d = count_q - ONE;
            busy_d  = (count_q == ONE) ? 1'b0 : busy_q;
        end else begin
            busy_d  = busy_q;
            count_d = count_q;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o      = busy_q;
    assign busy_next_o = busy_d;
    assign count_o     = count_q;

endmodule

// File: rtl/chord_voice_allocator.sv
// Accepts notes over a valid/ready handshake and assigns each one to a voice.
// A note goes to the lowest-index free voice. If no voice is free, it either steals the voice nearest expiry or stalls.
module chord_voice_allocator
    import chord_voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int STEAL_EN   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  beat,
    input  logic                  req_valid,
    input  logic [NOTE_W-1:0]     req_note,
    input  logic [DUR_W-1:0]      req_duration,
    output logic                  req_ready,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [DUR_W-1:0]      voice_duration,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  steal_pulse,
    output logic                  all_idle
);

    localparam int   IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic STEAL_ON = (STEAL_EN != 0);

    state_e               state_q;
    logic [NOTE_W-1:0]    note_q;
    logic [DUR_W-1:0]     dur_q;

    logic [NUM_VOICES-1:0] busy_s;
    logic [NUM_VOICES-1:0] busy_next_s;
    logic [DUR_W-1:0]      count_s [NUM_VOICES];

    logic                  any_free_s;
    logic [IDX_W-1:0]      free_idx_s;
    logic [IDX_W-1:0]      min_idx_s;
    logic [DUR_W-1:0]      min_cnt_s;
    logic [IDX_W-1:0]      target_s;
    logic                  is_rest_s;
    logic                  strobe_s;
    logic [NUM_VOICES-1:0] load_s;

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_slot
            voice_slot #(.DUR_W(DUR_W)) u_slot (
                .clk          (clk),
                .reset        (reset),
                .play_enable_i(play_enable),
                .beat_i       (beat),
                .load_i       (load_s[g]),
                .done_i       (voice_done[g]),
                .load_dur_i   (dur_q),
                .busy_o       (busy_s[g]),
                .busy_next_o  (busy_next_s[g]),
                .count_o      (count_s[g])
            );
        end
    endgenerate

    // Target selection: lowest free index. If none is free, the smallest remaining count wins, with ties going to the lower index.
    always_comb begin
        any_free_s = ~&busy_s;
        free_idx_s = '0;
        min_idx_s  = '0;
        min_cnt_s  = count_s[0];
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!busy_s[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (count_s[i] < min_cnt_s) begin
                min_cnt_s = count_s[i];
                min_idx_s = IDX_W'(i);
            end else begin
                min_cnt_s = min_cnt_s;
            end
        end
        target_s = any_free_s ? free_idx_s : min_idx_s;
    end

    assign is_rest_s = (note_q == NOTE_W'(REST_NOTE)) || (dur_q == '0);
    assign strobe_s  = (state_q == ST_GRANT) && play_enable && !is_rest_s && (any_free_s || STEAL_ON);
    assign load_s    = strobe_s ? (NUM_VOICES'(1) << target_s) : '0;

    // Handshake FSM. The pending note stays latched until it is granted or dropped as a rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        note_q  <= req_note;
                        dur_q   <= req_duration;
                        state_q <= ST_GRANT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!play_enable) begin
                        state_q <= ST_GRANT;
                    end else if (is_rest_s || any_free_s || STEAL_ON) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (~&busy_next_s) begin
                        state_q <= ST_GRANT;
                    end else begin
                        state_q <= ST_STALL;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign voice_load     = load_s;
    assign voice_note     = strobe_s ? note_q : '0;
    assign voice_duration = strobe_s ? dur_q : '0;
    assign voice_busy     = busy_s;
    assign steal_pulse    = strobe_s && !any_free_s;
    assign all_idle       = (busy_s == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_chord_voice_allocator.sv
// Directed bench for chord_voice_allocator: a per-cycle vector table followed by hand sequences for steal, stall and reset.
module tb_chord_voice_allocator;

    logic       clk;
    logic       reset;
    logic       play_enable;
    logic       beat;
    logic       req_valid;
    logic [5:0] req_note;
    logic [5:0] req_duration;
    logic [2:0] voice_done;

    logic       rdy, steal, idle;
    logic [2:0] load, busy;
    logic [5:0] vnote, vdur;
    logic       ns_rdy, ns_steal, ns_idle;
    logic [2:0] ns_load, ns_busy;
    logic [5:0] ns_vnote, ns_vdur;

    int checks   = 0;
    int failures = 0;

    chord_voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .STEAL_EN(1)) dut (
        .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
        .req_valid(req_valid), .req_note(req_note), .req_duration(req_duration),
        .req_ready(rdy), .voice_done(voice_done), .voice_load(load),
        .voice_note(vnote), .voice_duration(vdur), .voice_busy(busy),
        .steal_pulse(steal), .all_idle(idle)
    );

    chord_voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .STEAL_EN(0)) dut_ns (
        .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
        .req_valid(req_valid), .req_note(req_note), .req_duration(req_duration),
        .req_ready(ns_rdy), .voice_done(voice_done), .voice_load(ns_load),
        .voice_note(ns_vnote), .voice_duration(ns_vdur), .voice_busy(ns_busy),
        .steal_pulse(ns_steal), .all_idle(ns_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [5:0] n;
        logic [5:0] d;
        logic       bt;
        logic [2:0] dn;
        logic       pe;
        logic [2:0] e_load;
        logic [2:0] e_busy;
        logic       e_rdy;
        logic       e_steal;
        logic [5:0] e_note;
        logic [5:0] e_dur;
        logic       e_idle;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic v, logic [5:0] n, logic [5:0] d, logic bt, logic [2:0] dn, logic pe,
                                logic [2:0] el, logic [2:0] eb, logic er, logic es,
                                logic [5:0] en, logic [5:0] ed, logic ei);
        vec_t r;
        r.v = v; r.n = n; r.d = d; r.bt = bt; r.dn = dn; r.pe = pe;
        r.e_load = el; r.e_busy = eb; r.e_rdy = er; r.e_steal = es;
        r.e_note = en; r.e_dur = ed; r.e_idle = ei;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_note     = 6'd0;
        req_duration = 6'd0;
        beat         = 1'b0;
        voice_done   = 3'b000;
        play_enable  = 1'b1;
    endtask

    // Offers one note to both instances and checks the strobe that follows.
    task automatic send(input logic [5:0] n, input logic [5:0] d, input logic [2:0] exp_load);
        req_valid = 1'b1; req_note = n; req_duration = d;
        #2;
        chk("send ready", {31'd0, rdy}, 32'd1);
        tick();
        req_valid = 1'b0; req_note = 6'd0; req_duration = 6'd0;
        #2;
        chk("send load", {29'd0, load}, {29'd0, exp_load});
        chk("send ns load", {29'd0, ns_load}, {29'd0, exp_load});
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        tbl[0]  = mk(1'b1, 6'd10, 6'd4, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 6'd0,  6'd0, 1'b1);
        tbl[1]  = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 6'd10, 6'd4, 1'b0);
        tbl[2]  = mk(1'b1, 6'd20, 6'd8, 1'b0, 3'b000, 1'b1, 3'b000, 3'b001, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[3]  = mk(1'b0, 6'd0,  6'd0, 1'b0, 3'b000, 1'b1, 3'b010, 3'b001, 1'b0, 1'b0, 6'd20, 6'd8, 1'b0);
        tbl[4]  = mk(1'b1, 6'd30, 6'd2, 1'b0, 3'b000, 1'b1, 3'b000, 3'b011, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[5]  = mk(1'b0, 6'd0,  6'd0, 1'b0, 3'b000, 1'b1, 3'b100, 3'b011, 1'b0, 1'b0, 6'd30, 6'd2, 1'b0);
        tbl[6]  = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b1, 3'b000, 3'b111, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[7]  = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b1, 3'b000, 3'b111, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[8]  = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b1, 3'b000, 3'b011, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[9]  = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b1, 3'b000, 3'b011, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[10] = mk(1'b0, 6'd0,  6'd0, 1'b0, 3'b111, 1'b1, 3'b000, 3'b010, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[11] = mk(1'b1, 6'd0,  6'd3, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 6'd0,  6'd0, 1'b1);
        tbl[12] = mk(1'b0, 6'd0,  6'd0, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[13] = mk(1'b1, 6'd5,  6'd0, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 6'd0,  6'd0, 1'b1);
        tbl[14] = mk(1'b0, 6'd0,  6'd0, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[15] = mk(1'b1, 6'd7,  6'd3, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 6'd0,  6'd0, 1'b1);
        tbl[16] = mk(1'b0, 6'd0,  6'd0, 1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 6'd7,  6'd3, 1'b0);
        tbl[17] = mk(1'b1, 6'd9,  6'd2, 1'b1, 3'b000, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[18] = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[19] = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[20] = mk(1'b0, 6'd0,  6'd0, 1'b0, 3'b000, 1'b1, 3'b010, 3'b001, 1'b0, 1'b0, 6'd9,  6'd2, 1'b0);
        tbl[21] = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b1, 3'b000, 3'b011, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[22] = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b1, 3'b000, 3'b011, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[23] = mk(1'b0, 6'd0,  6'd0, 1'b1, 3'b000, 1'b1, 3'b000, 3'b001, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0);
        tbl[24] = mk(1'b0, 6'd0,  6'd0, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 6'd0,  6'd0, 1'b1);

        // Reset state.
        repeat (2) @(posedge clk);
        #3;
        chk("rst load", {29'd0, load}, 32'd0);
        chk("rst busy", {29'd0, busy}, 32'd0);
        chk("rst ready", {31'd0, rdy}, 32'd1);
        chk("rst idle", {31'd0, idle}, 32'd1);
        chk("rst note", {26'd0, vnote}, 32'd0);
        chk("rst dur", {26'd0, vdur}, 32'd0);
        chk("rst steal", {31'd0, steal}, 32'd0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            req_valid = tbl[i].v; req_note = tbl[i].n; req_duration = tbl[i].d;
            beat = tbl[i].bt; voice_done = tbl[i].dn; play_enable = tbl[i].pe;
            #2;
            chk($sformatf("row%0d load", i), {29'd0, load}, {29'd0, tbl[i].e_load});
            chk($sformatf("row%0d busy", i), {29'd0, busy}, {29'd0, tbl[i].e_busy});
            chk($sformatf("row%0d ready", i), {31'd0, rdy}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("row%0d steal", i), {31'd0, steal}, {31'd0, tbl[i].e_steal});
            chk($sformatf("row%0d note", i), {26'd0, vnote}, {26'd0, tbl[i].e_note});
            chk($sformatf("row%0d dur", i), {26'd0, vdur}, {26'd0, tbl[i].e_dur});
            chk($sformatf("row%0d idle", i), {31'd0, idle}, {31'd0, tbl[i].e_idle});
            chk($sformatf("row%0d ns load", i), {29'd0, ns_load}, {29'd0, tbl[i].e_load});
            chk($sformatf("row%0d ns busy", i), {29'd0, ns_busy}, {29'd0, tbl[i].e_busy});
            tick();
        end
        idle_inputs();

        // Fill the voices with remaining counts {5,2,2}. The fourth note is stolen by dut and stalls in dut_ns.
        send(6'd1, 6'd5, 3'b001);
        send(6'd2, 6'd2, 3'b010);
        send(6'd3, 6'd2, 3'b100);
        req_valid = 1'b1; req_note = 6'd40; req_duration = 6'd6;
        #2;
        chk("steal accept ready", {31'd0, rdy}, 32'd1);
        tick();
        req_valid = 1'b0; req_note = 6'd0; req_duration = 6'd0;
        #2;
        chk("steal load", {29'd0, load}, 32'd2);
        chk("steal pulse", {31'd0, steal}, 32'd1);
        chk("steal note", {26'd0, vnote}, 32'd40);
        chk("steal dur", {26'd0, vdur}, 32'd6);
        chk("ns grant no load", {29'd0, ns_load}, 32'd0);
        chk("ns grant ready", {31'd0, ns_rdy}, 32'd0);
        tick();
        #2;
        chk("ns stall ready", {31'd0, ns_rdy}, 32'd0);
        chk("ns stall load", {29'd0, ns_load}, 32'd0);
        chk("ns stall steal", {31'd0, ns_steal}, 32'd0);
        voice_done = 3'b100;
        tick();
        voice_done = 3'b000;
        #2;
        chk("ns unstall load", {29'd0, ns_load}, 32'd4);
        chk("ns unstall note", {26'd0, ns_vnote}, 32'd40);
        chk("ns unstall steal", {31'd0, ns_steal}, 32'd0);
        chk("steal side busy", {29'd0, busy}, 32'd3);
        tick();

        // dut counts are now {5,6,0} and dut_ns counts are {5,2,6}.
        for (int b = 0; b < 5; b++) begin
            beat = 1'b1;
            tick();
            beat = 1'b0;
        end
        #2;
        chk("count1 after 5 beats", {29'd0, busy}, 32'd2);
        chk("ns after 5 beats", {29'd0, ns_busy}, 32'd4);
        beat = 1'b1;
        tick();
        beat = 1'b0;
        #2;
        chk("count1 after 6 beats", {29'd0, busy}, 32'd0);
        chk("ns after 6 beats", {29'd0, ns_busy}, 32'd0);
        chk("idle after drain", {31'd0, idle}, 32'd1);
        tick();

        // Assert reset while a note is pending in GRANT.
        send(6'd12, 6'd9, 3'b001);
        req_valid = 1'b1; req_note = 6'd11; req_duration = 6'd3;
        tick();
        req_valid = 1'b0; req_note = 6'd0; req_duration = 6'd0;
        #2;
        chk("pre-reset grant load", {29'd0, load}, 32'd2);
        reset = 1'b0;
        #2;
        chk("mid rst load", {29'd0, load}, 32'd0);
        chk("mid rst busy", {29'd0, busy}, 32'd0);
        chk("mid rst ready", {31'd0, rdy}, 32'd1);
        chk("mid rst idle", {31'd0, idle}, 32'd1);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("post rst load c%0d", c), {29'd0, load}, 32'd0);
            chk($sformatf("post rst ready c%0d", c), {31'd0, rdy}, 32'd1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
